// File: rtl/mem_sram_bridge.sv
// Data-memory bridge between MEM's single-cycle RAM port and the SRAM-like
// req/addr_ok/data_ok bus; one outstanding transaction, pipeline stalled meanwhile.
module mem_sram_bridge #(
  parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_wdata_i,
  input  logic        flush_i,
  input  logic        pipe_stall_i,
  output logic [31:0] ram_data_o,
  output logic        stallreq_o,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ram_data_q, ram_data_d;
  logic        discard_q, discard_d;
  logic        discard_now;

  function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
    logic [1:0] size;
    case (sel)
      4'b1111:                            size = 2'd2;
      4'b0011, 4'b1100:                   size = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
      default:                            size = 2'd2;
    endcase
    return size;
  endfunction

  // Bus handshake: data_req_o stays high with stable fields until the cycle
  // data_addr_ok_i is seen; data_data_ok_i (possibly in that same cycle)
  // ends the transaction. A flush never withdraws a request, it only marks
  // the result to be dropped.
  assign discard_now = discard_q | flush_i;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    wr_d       = wr_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ram_data_d = ram_data_q;
    discard_d  = discard_q;
    case (state_q)
      S_IDLE: begin
        if (ram_ce_i && !flush_i) begin
          state_d   = S_REQ;
          req_d     = 1'b1;
          wr_d      = ram_we_i;
          size_d    = sel_to_size(ram_sel_i);
          addr_d    = ram_addr_i & ADDR_MASK;
          wdata_d   = ram_wdata_i;
          discard_d = 1'b0;
        end
      end
      S_REQ: begin
        if (flush_i) discard_d = 1'b1;
        if (data_addr_ok_i) begin
          req_d = 1'b0;
          if (data_data_ok_i) begin
            discard_d = 1'b0;
            if (discard_now) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_HOLD;
              if (!wr_q) ram_data_d = data_rdata_i;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush_i) discard_d = 1'b1;
        if (data_data_ok_i) begin
          discard_d = 1'b0;
          if (discard_now) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
            if (!wr_q) ram_data_d = data_rdata_i;
          end
        end
      end
      S_HOLD: begin
        if (flush_i || !pipe_stall_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      ram_data_q <= 32'd0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      wr_q       <= wr_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ram_data_q <= ram_data_d;
      discard_q  <= discard_d;
    end
  end

  // Reset also masks the stall so the pipeline is released immediately.
  assign stallreq_o = !rst_i &&
                      (((state_q == S_IDLE) && ram_ce_i && !flush_i) ||
                       (state_q == S_REQ) || (state_q == S_WAIT));

  assign data_req_o   = req_q;
  assign data_wr_o    = wr_q;
  assign data_size_o  = size_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;
  assign ram_data_o   = ram_data_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_sram_bridge.sv
// Directed self-checking bench for mem_sram_bridge with a small bus responder.
module tb_mem_sram_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ram_ce_i, ram_we_i;
  logic [3:0]  ram_sel_i;
  logic [31:0] ram_addr_i, ram_wdata_i;
  logic        flush_i, pipe_stall_i;
  logic [31:0] ram_data_o;
  logic        stallreq_o, data_req_o, data_wr_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_addr_ok_i, data_data_ok_i;
  logic [31:0] data_rdata_i;
  logic [1:0]  dbg_state_o;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_HOLD = 2'd3;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rd;

  mem_sram_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_sel_i(ram_sel_i),
    .ram_addr_i(ram_addr_i), .ram_wdata_i(ram_wdata_i),
    .flush_i(flush_i), .pipe_stall_i(pipe_stall_i),
    .ram_data_o(ram_data_o), .stallreq_o(stallreq_o),
    .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i),
    .data_rdata_i(data_rdata_i), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata);
    ram_ce_i    = 1'b1;
    ram_we_i    = we;
    ram_sel_i   = sel;
    ram_addr_i  = addr;
    ram_wdata_i = wdata;
  endtask

  // Bus slave: addr_ok on the aok_n-th request cycle, data_ok dok_n cycles
  // later (0 = same cycle). Starts in the cycle MEM presents the access and
  // returns at +1 after the edge that follows data_ok.
  task automatic bus_txn(input int aok_n, input int dok_n, input logic [31:0] rdata,
                         input int flush_at, output int stall_n, output int req_n);
    int  reqc = 0;
    int  waitc = 0;
    bit  accepted = 0;
    bit  done = 0;
    stall_n = 0;
    req_n   = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b0;
      data_rdata_i   = $urandom;
      flush_i        = (cyc == flush_at);
      if (cyc == flush_at) ram_ce_i = 1'b0;
      if (data_req_o && !accepted) begin
        reqc++;
        if (reqc == aok_n) begin
          data_addr_ok_i = 1'b1;
          accepted = 1;
          if (dok_n == 0) begin
            data_data_ok_i = 1'b1;
            data_rdata_i   = rdata;
            done = 1;
          end
        end
      end else if (accepted) begin
        waitc++;
        if (waitc == dok_n) begin
          data_data_ok_i = 1'b1;
          data_rdata_i   = rdata;
          done = 1;
        end
      end
      @(negedge clk_i);
      if (stallreq_o) stall_n++;
      if (data_req_o) req_n++;
      step();
    end
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b0;
    flush_i        = 1'b0;
    check_eq("bus_txn_done", 32'(done), 32'd1);
  endtask

  task automatic leave_hold();
    pipe_stall_i = 1'b0;
    step();
    ram_ce_i = 1'b0;
    @(negedge clk_i);
    check_eq("leave_state", 32'(dbg_state_o), 32'(ST_IDLE));
    check_eq("leave_stall", 32'(stallreq_o), 32'd0);
    step();
  endtask

  initial begin
    int st, rq;
    rst_i = 1'b1;
    ram_ce_i = 0; ram_we_i = 0; ram_sel_i = 0; ram_addr_i = 0; ram_wdata_i = 0;
    flush_i = 0; pipe_stall_i = 0;
    data_addr_ok_i = 0; data_data_ok_i = 0; data_rdata_i = 0;
    #12;
    @(negedge clk_i);
    check_eq("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
    check_eq("rst_req", 32'(data_req_o), 32'd0);
    check_eq("rst_wr", 32'(data_wr_o), 32'd0);
    check_eq("rst_size", 32'(data_size_o), 32'd0);
    check_eq("rst_addr", data_addr_o, 32'd0);
    check_eq("rst_wdata", data_wdata_o, 32'd0);
    check_eq("rst_rdata", ram_data_o, 32'd0);
    check_eq("rst_stall", 32'(stallreq_o), 32'd0);
    rst_i = 1'b0;
    step();

    // word load, zero-wait bus
    issue(1'b0, 4'hF, 32'h8000_0010, 32'h0);
    exp_q.push_back(32'hDEAD_BEEF);
    bus_txn(1, 0, 32'hDEAD_BEEF, -1, st, rq);
    @(negedge clk_i);
    exp_rd = exp_q.pop_front();
    check_eq("wl_stall_cycles", 32'(st), 32'd2);
    check_eq("wl_req_cycles", 32'(rq), 32'd1);
    check_eq("wl_state", 32'(dbg_state_o), 32'(ST_HOLD));
    check_eq("wl_hold_stall", 32'(stallreq_o), 32'd0);
    check_eq("wl_rdata", ram_data_o, exp_rd);
    check_eq("wl_addr", data_addr_o, 32'h0000_0010);
    check_eq("wl_size", 32'(data_size_o), 32'd2);
    check_eq("wl_wr", 32'(data_wr_o), 32'd0);
    leave_hold();

    // byte store, 3-cycle addr_ok, 2-cycle data_ok
    issue(1'b1, 4'b0100, 32'h0000_0102, 32'h00AB_0000);
    bus_txn(3, 2, 32'h5555_5555, -1, st, rq);
    @(negedge clk_i);
    check_eq("bs_stall_cycles", 32'(st), 32'd6);
    check_eq("bs_req_cycles", 32'(rq), 32'd3);
    check_eq("bs_wr", 32'(data_wr_o), 32'd1);
    check_eq("bs_size", 32'(data_size_o), 32'd0);
    check_eq("bs_addr", data_addr_o, 32'h0000_0102);
    check_eq("bs_wdata", data_wdata_o, 32'h00AB_0000);
    check_eq("bs_rdata_kept", ram_data_o, 32'hDEAD_BEEF);
    check_eq("bs_state", 32'(dbg_state_o), 32'(ST_HOLD));
    leave_hold();

    // half load completing under external stall
    pipe_stall_i = 1'b1;
    issue(1'b0, 4'b0011, 32'hA000_0204, 32'h0);
    exp_q.push_back(32'h1234_5678);
    bus_txn(2, 1, 32'h1234_5678, -1, st, rq);
    exp_rd = exp_q.pop_front();
    check_eq("hs_stall_cycles", 32'(st), 32'd4);
    check_eq("hs_addr", data_addr_o, 32'h0000_0204);
    check_eq("hs_size", 32'(data_size_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check_eq("hs_state", 32'(dbg_state_o), 32'(ST_HOLD));
      check_eq("hs_rdata", ram_data_o, exp_rd);
      check_eq("hs_no_req", 32'(data_req_o), 32'd0);
      step();
    end
    leave_hold();

    // flush during WAIT, data_ok two cycles later
    issue(1'b0, 4'b0001, 32'h0000_0033, 32'h0);
    bus_txn(1, 3, 32'hFFFF_FFFF, 2, st, rq);
    @(negedge clk_i);
    check_eq("fw_stall_cycles", 32'(st), 32'd5);
    check_eq("fw_state", 32'(dbg_state_o), 32'(ST_IDLE));
    check_eq("fw_rdata_kept", ram_data_o, 32'h1234_5678);
    check_eq("fw_stall_after", 32'(stallreq_o), 32'd0);
    check_eq("fw_size", 32'(data_size_o), 32'd0);
    step();

    // flush in REQ before addr_ok
    issue(1'b0, 4'b1100, 32'h3FFF_FFFC, 32'h0);
    bus_txn(3, 1, 32'hCAFE_0000, 1, st, rq);
    @(negedge clk_i);
    check_eq("fr_req_cycles", 32'(rq), 32'd3);
    check_eq("fr_stall_cycles", 32'(st), 32'd5);
    check_eq("fr_state", 32'(dbg_state_o), 32'(ST_IDLE));
    check_eq("fr_rdata_kept", ram_data_o, 32'h1234_5678);
    check_eq("fr_addr", data_addr_o, 32'h1FFF_FFFC);
    check_eq("fr_size", 32'(data_size_o), 32'd1);
    step();

    // flush in IDLE masks ram_ce_i
    issue(1'b0, 4'hF, 32'h0000_0080, 32'h0);
    flush_i = 1'b1;
    @(negedge clk_i);
    check_eq("fi_stall", 32'(stallreq_o), 32'd0);
    step();
    flush_i = 1'b0;
    ram_ce_i = 1'b0;
    @(negedge clk_i);
    check_eq("fi_state", 32'(dbg_state_o), 32'(ST_IDLE));
    check_eq("fi_req", 32'(data_req_o), 32'd0);
    step();

    // flush while in HOLD
    pipe_stall_i = 1'b1;
    issue(1'b0, 4'b1000, 32'h0000_0040, 32'h0);
    bus_txn(1, 0, 32'h0BAD_F00D, -1, st, rq);
    @(negedge clk_i);
    check_eq("fh_state", 32'(dbg_state_o), 32'(ST_HOLD));
    check_eq("fh_rdata", ram_data_o, 32'h0BAD_F00D);
    step();
    flush_i = 1'b1;
    ram_ce_i = 1'b0;
    step();
    flush_i = 1'b0;
    pipe_stall_i = 1'b0;
    @(negedge clk_i);
    check_eq("fh_idle", 32'(dbg_state_o), 32'(ST_IDLE));
    check_eq("fh_rdata_kept", ram_data_o, 32'h0BAD_F00D);
    step();

    // async reset in the middle of REQ
    issue(1'b0, 4'hF, 32'h0000_0100, 32'h0);
    step();
    check_eq("ar_req_before", 32'(data_req_o), 32'd1);
    check_eq("ar_state_before", 32'(dbg_state_o), 32'(ST_REQ));
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("ar_req", 32'(data_req_o), 32'd0);
    check_eq("ar_stall", 32'(stallreq_o), 32'd0);
    check_eq("ar_state", 32'(dbg_state_o), 32'(ST_IDLE));
    check_eq("ar_rdata", ram_data_o, 32'd0);
    ram_ce_i = 1'b0;
    step();
    rst_i = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_sram_bridge.md
# mem_sram_bridge

Multi-cycle data-memory bridge directly downstream of the MEM stage. Converts MEM's single-cycle RAM port (ce/we/sel/addr/wdata, read data expected back) into the SRAM-like request/addr_ok/data_ok bus, stalls the pipeline while a transaction is outstanding, and returns read data to MEM's `ram_data_i`. It holds completed read data stable until the pipeline advances, and handles exception flushes without violating the bus handshake.

## Interface
- `ADDR_MASK`, default 32'h1FFF_FFFF: mask applied to the virtual address to form the physical bus address.
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `ram_ce_i`  in  1  MEM requests a memory access this cycle
- `ram_we_i`  in  1  1 = store, 0 = load
- `ram_sel_i`  in  4  byte enables from MEM
- `ram_addr_i`  in  32  byte address from MEM
- `ram_wdata_i`  in  32  store data, already lane-aligned
- `flush_i`  in  1  exception flush; the instruction in MEM is cancelled
- `pipe_stall_i`  in  1  stall from all other sources; never includes `stallreq_o`
- `ram_data_o`  out  32  load data to MEM
- `stallreq_o`  out  1  stall request to the pipeline controller
- `data_req_o`  out  1  bus request
- `data_wr_o`  out  1  bus write
- `data_size_o`  out  2  0 = byte, 1 = half, 2 = word
- `data_addr_o`  out  32  physical byte address
- `data_wdata_o`  out  32  bus write data
- `data_addr_ok_i`  in  1  request accepted
- `data_data_ok_i`  in  1  transaction complete; read data valid
- `data_rdata_i`  in  32  bus read data

## Operation
- **States:** IDLE, REQ, WAIT, HOLD.
- **Reset:** state IDLE. All registered outputs are 0: `data_req_o`, `data_wr_o`, `data_size_o`, `data_addr_o`, `data_wdata_o`, `ram_data_o`. `stallreq_o` is 0 while `ram_ce_i` = 0.
- **IDLE:**
  - If `ram_ce_i` = 1 and `flush_i` = 0: latch `wr = ram_we_i`, `addr = ram_addr_i & ADDR_MASK`, wdata, and size, then go to REQ.
  - If `flush_i` = 1, ignore `ram_ce_i`.
- **Size decode from `ram_sel_i`:**
  - 4'b1111 gives 2.
  - 4'b0011 or 4'b1100 gives 1.
  - Any one-hot value gives 0.
  - Any other pattern gives 2.
- **REQ:**
  - `data_req_o` = 1 with the latched fields.
  - On `data_addr_ok_i` with `data_data_ok_i` in the same cycle: capture read data, go to HOLD.
  - On `data_addr_ok_i` alone: go to WAIT.
  - `data_req_o` is never withdrawn before `data_addr_ok_i`, even under flush.
- **WAIT:** `data_req_o` = 0. On `data_data_ok_i`, go to HOLD; for a load, `ram_data_o <= data_rdata_i`.
- **HOLD:**
  - `ram_data_o` is held stable.
  - If `pipe_stall_i` = 0, go to IDLE: the instruction leaves MEM at this edge.
  - If `pipe_stall_i` = 1, stay in HOLD. No re-issue of the access.
- **`stallreq_o`:** `(IDLE & ram_ce_i & ~flush_i) | REQ | WAIT`. It is 0 in HOLD.
- **Flush:**
  - `flush_i` in REQ or WAIT sets a `discard` flag.
  - The bus transaction still completes.
  - On `data_data_ok_i`, go to IDLE instead of HOLD and leave `ram_data_o` unchanged. Clear `discard`.
  - `stallreq_o` stays 1 until then.
  - `flush_i` in HOLD: go to IDLE.
- **Stores:** same flow as loads. `ram_data_o` is not updated.
- **Reset mid-transaction:** immediate return to IDLE, `data_req_o` = 0. The bus side is reset by the same `rst_i`.

## Timing
- **Minimum load latency:**
  - Cycle N: `ram_ce_i` seen, `stallreq_o` = 1.
  - Cycle N+1: REQ, `data_req_o` = 1; `addr_ok` and `data_ok` both arrive.
  - Cycle N+2: HOLD, `stallreq_o` = 0, `ram_data_o` valid.
  - The instruction advances at the end of N+2 if `pipe_stall_i` = 0.
- **General case:** each extra cycle before `addr_ok`, and each cycle between `addr_ok` and `data_ok`, adds one cycle of stall.
- **Registered outputs:** the `data_*` outputs and `ram_data_o` are registered.
- **Combinational output:** `stallreq_o` is combinational from state and `ram_ce_i`/`flush_i`.
- **Outstanding transactions:** at most one at any time.

## Test plan
- **Word load, zero-wait bus:**
  - Stimulus: `ram_ce_i` = 1, `we` = 0, `sel` = 4'hF, `addr` = 32'h8000_0010; `addr_ok` and `data_ok` in the first REQ cycle, `rdata` = 32'hDEAD_BEEF.
  - Required: `data_addr_o` = 32'h0000_0010, `size` = 2. `stallreq_o` is high for 2 cycles. `ram_data_o` = 32'hDEAD_BEEF in HOLD.
- **Byte store with 3-cycle addr_ok delay and 2-cycle data_ok delay:**
  - Stimulus: `sel` = 4'b0100.
  - Required: `data_wr_o` = 1, `size` = 0. `data_req_o` high for exactly 3 cycles. `stallreq_o` high for 1+3+2 cycles.
- **HOLD under external stall:**
  - Stimulus: load completes with `rdata` = 32'h1234_5678 while `pipe_stall_i` = 1 for 4 cycles.
  - Required: state stays HOLD, `ram_data_o` stable at 32'h1234_5678, no new `data_req_o`. IDLE on the cycle after `pipe_stall_i` falls.
- **Flush during WAIT:**
  - Stimulus: `flush_i` pulses while WAIT; `data_ok` 2 cycles later with `rdata` = 32'hFFFF_FFFF.
  - Required: `ram_data_o` keeps its previous value, next state IDLE, `stallreq_o` drops after `data_ok`.
- **Flush in REQ before addr_ok:**
  - Required: `data_req_o` stays 1 until `addr_ok`, then the transaction completes silently.
- **Async reset mid-REQ:**
  - Stimulus: `rst_i` asserted between clock edges.
  - Required: `data_req_o` = 0 and `stallreq_o` = 0 immediately, without waiting for a clock edge.
